// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC, branch redirect with younger-slot squash, and BL link write
module pc_sequencer #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stall,
  input  logic            taken,
  input  logic            is_bl,
  input  logic            is_bx,
  input  logic [PC_W-1:0] branch_pc,
  input  logic [PC_W-1:0] offset,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            link_we,
  output logic [PC_W-1:0] link_data
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [PC_W-1:0] pc_n, link_data_n, ret, target, pc_inc;
  logic link_we_n;
  assign ret = branch_pc + PC_W'(1);
  assign target = is_bx ? reg_target : ret + offset;
  assign pc_inc = pc + PC_W'(1);
  assign fetch_valid = state == RUN;
  assign flush = state == FLUSH;
  // A taken seen in FLUSH belongs to a squashed instruction and is dropped.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_n = pc;
    link_we_n = 1'b0;
    link_data_n = link_data;
    if (state == RUN) begin
      if (taken) begin
        state_n = FLUSH;
        cnt_n = 3'(FLUSH_SLOTS);
        pc_n = target;
        link_we_n = is_bl;
        link_data_n = is_bl ? ret : link_data;
      end else begin
        pc_n = stall ? pc : pc_inc;
      end
    end else if (!stall) begin
      cnt_n = cnt - 3'd1;
      pc_n = pc_inc;
      state_n = cnt == 3'd1 ? RUN : FLUSH;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      cnt <= '0;
      pc <= RESET_PC;
      link_we <= 1'b0;
      link_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc <= pc_n;
      link_we <= link_we_n;
      link_data <= link_data_n;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors against hand-computed PC, flush and link expectations
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic resetn, stall, taken, is_bl, is_bx;
  logic [15:0] branch_pc, offset, reg_target, pc, link_data;
  logic fetch_valid, flush, link_we;
  int checks = 0;
  int errors = 0;
  pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_SLOTS(2)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .taken(taken), .is_bl(is_bl),
    .is_bx(is_bx), .branch_pc(branch_pc), .offset(offset), .reg_target(reg_target),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .link_we(link_we),
    .link_data(link_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic st(input string tag, input logic [15:0] p, input logic fv, input logic fl,
                    input logic lw);
    chk({tag, " pc"}, pc, p);
    chk({tag, " fetch_valid"}, 16'(fetch_valid), 16'(fv));
    chk({tag, " flush"}, 16'(flush), 16'(fl));
    chk({tag, " link_we"}, 16'(link_we), 16'(lw));
  endtask
  task automatic br(input logic t, input logic bl, input logic bx, input logic [15:0] bpc,
                    input logic [15:0] off, input logic [15:0] rt);
    taken = t; is_bl = bl; is_bx = bx; branch_pc = bpc; offset = off; reg_target = rt;
  endtask
  initial begin
    resetn = 1'b0; stall = 1'b0;
    br(0, 0, 0, 0, 0, 0);
    #2;
    st("reset", 16'h0000, 1, 0, 0);
    chk("reset link_data", link_data, 16'h0000);
    step();
    resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      st($sformatf("free%0d", i), 16'(i), 1, 0, 0);
    end
    br(1, 0, 0, 16'h0010, 16'h0005, 0);
    step(); st("b redirect", 16'h0016, 0, 1, 0);
    br(0, 0, 0, 0, 0, 0);
    step(); st("b flush2", 16'h0017, 0, 1, 0);
    step(); st("b done", 16'h0018, 1, 0, 0);
    br(1, 1, 0, 16'h0020, 16'hFFF0, 0);
    step(); st("bl redirect", 16'h0011, 0, 1, 1);
    chk("bl link_data", link_data, 16'h0021);
    br(0, 0, 0, 0, 0, 0);
    step(); st("bl flush2", 16'h0012, 0, 1, 0);
    chk("bl link_data hold", link_data, 16'h0021);
    step(); st("bl done", 16'h0013, 1, 0, 0);
    stall = 1'b1;
    br(1, 0, 1, 16'h0050, 16'h0003, 16'h1234);
    step(); st("bx stalled redirect", 16'h1234, 0, 1, 0);
    br(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); st($sformatf("bx stall%0d", i), 16'h1234, 0, 1, 0);
    end
    stall = 1'b0;
    step(); st("bx flush2", 16'h1235, 0, 1, 0);
    br(1, 1, 0, 16'h00FF, 16'h0000, 0);
    step(); st("squashed taken", 16'h1236, 1, 0, 0);
    chk("squashed link_data", link_data, 16'h0021);
    br(1, 0, 0, 16'h0200, 16'h0010, 0);
    step(); st("first run taken", 16'h0211, 0, 1, 0);
    br(0, 0, 0, 0, 0, 0);
    step(); step(); st("after b2", 16'h0213, 1, 0, 0);
    br(1, 0, 1, 0, 0, 16'hFFFD);
    step(); st("bx wrapprep", 16'hFFFD, 0, 1, 0);
    br(0, 0, 0, 0, 0, 0);
    step(); step(); st("pc ffff", 16'hFFFF, 1, 0, 0);
    step(); st("pc wrap", 16'h0000, 1, 0, 0);
    br(1, 0, 0, 16'hFFFF, 16'h0000, 0);
    step(); st("target wrap", 16'h0000, 0, 1, 0);
    br(0, 0, 0, 0, 0, 0);
    step(); step(); st("target wrap done", 16'h0002, 1, 0, 0);
    br(1, 1, 0, 16'h0040, 16'h0010, 0);
    step(); st("bl pre-reset", 16'h0051, 0, 1, 1);
    br(0, 0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1 st("async reset", 16'h0000, 1, 0, 0);
    chk("async reset link_data", link_data, 16'h0000);
    step();
    resetn = 1'b1;
    step(); st("post reset", 16'h0001, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
